// File: rtl/demux2_chan_buffer.sv
`default_nettype none
//============================================================================
// Module   : demux2_chan_buffer
// Purpose  : Two-channel elastic buffer placed behind demux2. The word picked
//            by `select` is pushed into that channel's FIFO. Each FIFO drains
//            on its own valid/ready port, so either branch can stall without
//            losing data.
// Revision : 1.0 - initial release
//
// Build option:
//   DEMUX2_CHAN_BUFFER_STATS_EN - adds per-channel saturating stall counters
//
// Ports:
//   clk, rst_n                   - clock, synchronous active-low reset
//   in_valid, select             - upstream valid and demux routing select
//   output_data_0/1              - demux2 channel outputs (W bits)
//   in_ready                     - selected channel FIFO is not full
//   out_valid_0/1, out_data_0/1  - FIFO head (data forced to 0 when empty)
//   out_ready_0/1                - downstream accepts the head
//   count_0/1                    - channel occupancy, 0..DEPTH
//   stall_cnt_0/1                - rejected-push counters (stats build only)
//============================================================================
module demux2_chan_buffer #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic                     select,
  input  logic [W-1:0]             output_data_0,
  input  logic [W-1:0]             output_data_1,
  output logic                     in_ready,
  output logic                     out_valid_0,
  output logic                     out_valid_1,
  output logic [W-1:0]             out_data_0,
  output logic [W-1:0]             out_data_1,
  input  logic                     out_ready_0,
  input  logic                     out_ready_1,
  output logic [$clog2(DEPTH):0]   count_0,
  output logic [$clog2(DEPTH):0]   count_1
`ifdef DEMUX2_CHAN_BUFFER_STATS_EN
  ,
  output logic [7:0]               stall_cnt_0,
  output logic [7:0]               stall_cnt_1
`endif
);

  localparam int c_PW = $clog2(DEPTH);
  localparam int c_CW = c_PW + 1;

  logic [c_CW-1:0] w_count [2];
  logic [W-1:0]    w_head  [2];
  logic [1:0]      w_valid;
  logic [1:0]      w_full;
  logic [1:0]      w_sel_oh;
  logic [1:0]      w_out_ready;
  logic            w_push;
  logic [W-1:0]    w_wr_data;

  assign w_sel_oh    = {select, ~select};
  assign w_out_ready = {out_ready_1, out_ready_0};

  // Ready depends only on registered occupancy, so a pop on a full channel
  // frees the slot for the following cycle rather than bypassing.
  assign in_ready  = select ? ~w_full[1] : ~w_full[0];
  assign w_push    = in_valid & in_ready;
  assign w_wr_data = select ? output_data_1 : output_data_0;

  for (genvar c = 0; c < 2; c++) begin : g_chan
    logic [W-1:0]    r_mem [DEPTH];
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            w_push_c;
    logic            w_pop_c;

    assign w_push_c = w_push & w_sel_oh[c];
    assign w_pop_c  = w_valid[c] & w_out_ready[c];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push_c) r_wr_ptr <= r_wr_ptr + c_PW'(1);
        if (w_pop_c)  r_rd_ptr <= r_rd_ptr + c_PW'(1);
        if (w_push_c && !w_pop_c)      r_count <= r_count + c_CW'(1);
        else if (!w_push_c && w_pop_c) r_count <= r_count - c_CW'(1);
      end
    end

    // Storage needs no reset: contents are only visible through a non-zero count.
    always_ff @(posedge clk) begin
      if (rst_n && w_push_c) r_mem[r_wr_ptr] <= w_wr_data;
    end

    assign w_count[c] = r_count;
    assign w_valid[c] = (r_count != '0);
    assign w_full[c]  = (r_count == c_CW'(DEPTH));
    assign w_head[c]  = w_valid[c] ? r_mem[r_rd_ptr] : '0;

`ifdef DEMUX2_CHAN_BUFFER_STATS_EN
    logic [7:0] r_stall;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_stall <= '0;
      end else if (in_valid && !in_ready && w_sel_oh[c] && (r_stall != 8'hFF)) begin
        r_stall <= r_stall + 8'd1;
      end
    end
`endif
  end

  assign out_valid_0 = w_valid[0];
  assign out_valid_1 = w_valid[1];
  assign out_data_0  = w_head[0];
  assign out_data_1  = w_head[1];
  assign count_0     = w_count[0];
  assign count_1     = w_count[1];

`ifdef DEMUX2_CHAN_BUFFER_STATS_EN
  assign stall_cnt_0 = g_chan[0].r_stall;
  assign stall_cnt_1 = g_chan[1].r_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux2_chan_buffer.sv
`default_nettype none
//============================================================================
// Module   : tb_demux2_chan_buffer
// Purpose  : Self-checking bench for demux2_chan_buffer; a queue-per-channel
//            reference model predicts every output after each clock edge.
// Revision : 1.0 - initial release
//============================================================================
module tb_demux2_chan_buffer;
  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          select = 1'b0;
  logic [W-1:0]  output_data_0 = '0;
  logic [W-1:0]  output_data_1 = '0;
  logic          out_ready_0 = 1'b0;
  logic          out_ready_1 = 1'b0;
  logic          in_ready;
  logic          out_valid_0, out_valid_1;
  logic [W-1:0]  out_data_0, out_data_1;
  logic [CW-1:0] count_0, count_1;
`ifdef DEMUX2_CHAN_BUFFER_STATS_EN
  logic [7:0]    stall_cnt_0, stall_cnt_1;
  int            m_stall0 = 0;
  int            m_stall1 = 0;
`endif

  demux2_chan_buffer #(.W(W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .select        (select),
    .output_data_0 (output_data_0),
    .output_data_1 (output_data_1),
    .in_ready      (in_ready),
    .out_valid_0   (out_valid_0),
    .out_valid_1   (out_valid_1),
    .out_data_0    (out_data_0),
    .out_data_1    (out_data_1),
    .out_ready_0   (out_ready_0),
    .out_ready_1   (out_ready_1),
    .count_0       (count_0),
    .count_1       (count_1)
`ifdef DEMUX2_CHAN_BUFFER_STATS_EN
    ,
    .stall_cnt_0   (stall_cnt_0),
    .stall_cnt_1   (stall_cnt_1)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: one FIFO queue per channel.
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check_val({tag, " count_0"}, 32'(count_0), q0.size());
    check_val({tag, " count_1"}, 32'(count_1), q1.size());
    check_val({tag, " out_valid_0"}, 32'(out_valid_0), 32'(q0.size() != 0));
    check_val({tag, " out_valid_1"}, 32'(out_valid_1), 32'(q1.size() != 0));
    check_val({tag, " out_data_0"}, 32'(out_data_0), (q0.size() != 0) ? 32'(q0[0]) : 32'd0);
    check_val({tag, " out_data_1"}, 32'(out_data_1), (q1.size() != 0) ? 32'(q1[0]) : 32'd0);
`ifdef DEMUX2_CHAN_BUFFER_STATS_EN
    check_val({tag, " stall_cnt_0"}, 32'(stall_cnt_0), m_stall0);
    check_val({tag, " stall_cnt_1"}, 32'(stall_cnt_1), m_stall1);
`endif
  endtask

  // One clock: apply inputs, check in_ready, advance the model, check outputs.
  task automatic cycle(input string tag, input logic rn, input logic iv, input logic sel,
                       input logic [W-1:0] d0, input logic [W-1:0] d1,
                       input logic r0, input logic r1);
    bit acc, p0, p1, room;
    rst_n = rn; in_valid = iv; select = sel;
    output_data_0 = d0; output_data_1 = d1;
    out_ready_0 = r0; out_ready_1 = r1;
    #1;
    room = sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
    check_val({tag, " in_ready"}, 32'(in_ready), 32'(room));
    acc = iv && room;
    p0  = r0 && (q0.size() > 0);
    p1  = r1 && (q1.size() > 0);
    @(posedge clk);
    if (!rn) begin
      q0.delete();
      q1.delete();
`ifdef DEMUX2_CHAN_BUFFER_STATS_EN
      m_stall0 = 0;
      m_stall1 = 0;
`endif
    end else begin
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
      if (acc) begin
        if (sel) q1.push_back(d1);
        else     q0.push_back(d0);
      end
`ifdef DEMUX2_CHAN_BUFFER_STATS_EN
      if (iv && !acc) begin
        if (sel) begin if (m_stall1 < 255) m_stall1++; end
        else     begin if (m_stall0 < 255) m_stall0++; end
      end
`endif
    end
    #1;
    check_state(tag);
  endtask

  initial begin
    // Reset and idle
    cycle("rst", 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    cycle("rst", 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    cycle("idle", 1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
    check_val("idle in_ready", 32'(in_ready), 32'd1);
    check_val("idle count_0", 32'(count_0), 32'd0);

    // One word per channel; the unselected word is ignored
    cycle("push0", 1'b1, 1'b1, 1'b0, 16'hAAFF, 16'h1234, 1'b0, 1'b0);
    check_val("push0 out_data_0", 32'(out_data_0), 32'hAAFF);
    cycle("push1", 1'b1, 1'b1, 1'b1, 16'h5678, 16'hFF8F, 1'b0, 1'b0);
    check_val("push1 out_data_1", 32'(out_data_1), 32'hFF8F);
    check_val("push1 count_0", 32'(count_0), 32'd1);
    check_val("push1 count_1", 32'(count_1), 32'd1);
    cycle("rst2", 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);

    // Fill channel 0, reject a fifth word, then drain in order
    for (int i = 1; i <= 4; i++)
      cycle("fill0", 1'b1, 1'b1, 1'b0, W'(i), 16'hDEAD, 1'b0, 1'b0);
    check_val("full count_0", 32'(count_0), 32'd4);
    cycle("reject", 1'b1, 1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0);
    check_val("full in_ready", 32'(in_ready), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      check_val("drain head", 32'(out_data_0), 32'(i));
      cycle("drain0", 1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    end
    check_val("drained out_valid_0", 32'(out_valid_0), 32'd0);

    // Concurrent push and pop on channel 1 at count 2
    cycle("c1a", 1'b1, 1'b1, 1'b1, '0, 16'h0A0A, 1'b0, 1'b0);
    cycle("c1b", 1'b1, 1'b1, 1'b1, '0, 16'h0B0B, 1'b0, 1'b0);
    cycle("c1pp", 1'b1, 1'b1, 1'b1, '0, 16'h0C0C, 1'b0, 1'b1);
    check_val("pushpop count_1", 32'(count_1), 32'd2);
    check_val("pushpop head_1", 32'(out_data_1), 32'h0B0B);

    // Reset with three words stored, alongside a push
    cycle("w3", 1'b1, 1'b1, 1'b0, 16'h0077, '0, 1'b0, 1'b0);
    cycle("rstpush", 1'b0, 1'b1, 1'b0, 16'h0099, '0, 1'b0, 1'b0);
    check_val("rstpush count_0", 32'(count_0), 32'd0);
    check_val("rstpush count_1", 32'(count_1), 32'd0);
    check_val("rstpush out_valid_1", 32'(out_valid_1), 32'd0);

`ifdef DEMUX2_CHAN_BUFFER_STATS_EN
    for (int i = 0; i < 4; i++)
      cycle("sfill", 1'b1, 1'b1, 1'b0, W'(i), '0, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++)
      cycle("stall", 1'b1, 1'b1, 1'b0, 16'h0055, '0, 1'b0, 1'b0);
    check_val("stall_cnt_0 sat", 32'(stall_cnt_0), 32'd255);
    check_val("stall_cnt_1 idle", 32'(stall_cnt_1), 32'd0);
    cycle("srst", 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
`endif

    // Randomized traffic with occasional reset
    for (int i = 0; i < 2000; i++) begin
      cycle("rand", ($urandom_range(63) != 0), $urandom_range(1) == 1, $urandom_range(1) == 1,
            W'($urandom), W'($urandom),
            $urandom_range(2) == 0, $urandom_range(3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
